pipe_stall_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Collects hold requests from ID (load-use), EX (multi-cycle mul/div) and MEM (data SRAM wait), and exception requests.
- Drives the shared stall bus consumed by every stage register, plus a one-cycle flush with redirect PC.
- Sequences EX multi-cycle operations with an internal countdown.

---
 rtl/pipe_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush scheduler: merges ID/EX/MEM hold requests and exceptions into a prefix-mask stall bus.
// Optional performance counters are built only when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int          STALL_W      = 6,
    parameter int          MULTI_CYCLES = 32,
    parameter logic [31:0] EXC_VEC      = 32'hBFC0_0380
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               ex_multi_start,
    input  logic               mem_wait,
    input  logic               excp_req,
    output logic [STALL_W-1:0] stall,
    output logic               ex_multi_ready,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [31:0]        perf_stall_cycles,
    output logic [15:0]        perf_flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
    // The start cycle is the first EX occupancy cycle, so MULTI needs MULTI_CYCLES-1 visits ending at cnt==0.
    localparam logic [7:0]         CNT_LOAD   = 8'(MULTI_CYCLES - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_flush;
    logic [31:0] r_new_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flush <= (w_state_nxt == S_FLUSH);
            if (w_state_nxt == S_FLUSH) begin
                r_new_pc <= EXC_VEC;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (excp_req) begin
                    w_state_nxt = S_FLUSH;
                end else if (ex_multi_start) begin
                    w_state_nxt = S_MULTI;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_MULTI: begin
                if (excp_req) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end else if (!mem_wait) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = excp_req ? S_FLUSH : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // An exception in the completion cycle flushes the younger EX op, so its result is never reported.
    always_comb begin
        ex_multi_ready = 1'b0;
        stall          = STALL_NONE;
        if (!rst) begin
            ex_multi_ready = (r_state == S_MULTI) && (r_cnt == 8'd0) && !excp_req;
            if (r_flush) begin
                stall = STALL_NONE;
            end else if (mem_wait) begin
                stall = STALL_MEM;
            end else if ((r_state == S_MULTI) && (r_cnt != 8'd0)) begin
                stall = STALL_EX;
            end else if ((r_state == S_IDLE) && ex_multi_start) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

    assign flush  = r_flush;
    assign new_pc = r_new_pc;

`ifdef STALL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 16'd0;
        end else begin
            if (stall != STALL_NONE) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (r_flush && (r_perf_flush != 16'hFFFF)) begin
                r_perf_flush <= r_perf_flush + 16'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_cnt    = r_perf_flush;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a deadline-based reference model queues per-cycle expectations,
// a negedge monitor pops and compares them. Perf expectations follow STALL_PERF_EN.
module tb_pipe_stall_ctrl;

    localparam int          MC      = 4;
    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
    localparam int          W       = 88;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_multi_start;
    logic        mem_wait;
    logic        excp_req;
    logic [5:0]  stall;
    logic        ex_multi_ready;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_cnt;

    pipe_stall_ctrl #(
        .STALL_W      (6),
        .MULTI_CYCLES (MC),
        .EXC_VEC      (EXC_VEC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_id       (stallreq_id),
        .ex_multi_start    (ex_multi_start),
        .mem_wait          (mem_wait),
        .excp_req          (excp_req),
        .stall             (stall),
        .ex_multi_ready    (ex_multi_ready),
        .flush             (flush),
        .new_pc            (new_pc),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst            = 1'b1;
        stallreq_id    = 1'b0;
        ex_multi_start = 1'b0;
        mem_wait       = 1'b0;
        excp_req       = 1'b0;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int mon_cyc  = 0;
    int n_ready_seen = 0;

    // reference model: an op is a deadline cycle that slips by one for each mem_wait cycle before it
    int          cyc = 0;
    bit          m_op_active = 0;
    int          m_ready_cycle = 0;
    bit          m_flush_now = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_stall_cycles = 32'd0;
    logic [15:0] m_flush_cnt = 16'd0;

    task automatic drive(input logic r, input logic id, input logic st, input logic mw, input logic ex);
        logic [5:0]  e_stall;
        logic        e_ready;
        logic        e_flush;
        logic [31:0] e_psc;
        logic [15:0] e_pfc;
        bit          at_deadline;
        @(posedge clk);
        #1;
        rst            = r;
        stallreq_id    = id;
        ex_multi_start = st;
        mem_wait       = mw;
        excp_req       = ex;

        at_deadline = m_op_active && (cyc == m_ready_cycle);
        e_flush = m_flush_now;
        e_ready = 1'b0;
        e_stall = 6'b000000;
        if (!r) begin
            e_ready = at_deadline && !ex;
            if (m_flush_now)                    e_stall = 6'b000000;
            else if (mw)                        e_stall = 6'b011111;
            else if (m_op_active && !at_deadline) e_stall = 6'b001111;
            else if (!m_op_active && st)        e_stall = 6'b001111;
            else if (id)                        e_stall = 6'b000111;
        end
`ifdef STALL_PERF_EN
        e_psc = m_stall_cycles;
        e_pfc = m_flush_cnt;
`else
        e_psc = 32'd0;
        e_pfc = 16'd0;
`endif
        exp_q.push_back({e_stall, e_ready, e_flush, m_pc, e_psc, e_pfc});

        if (r) begin
            m_op_active    = 0;
            m_flush_now    = 0;
            m_pc           = 32'd0;
            m_stall_cycles = 32'd0;
            m_flush_cnt    = 16'd0;
        end else begin
            if (e_stall != 6'b000000) m_stall_cycles = m_stall_cycles + 32'd1;
            if (e_flush && m_flush_cnt != 16'hFFFF) m_flush_cnt = m_flush_cnt + 16'd1;
            if (m_op_active) begin
                if (ex || at_deadline) m_op_active = 0;
                else if (mw)           m_ready_cycle = m_ready_cycle + 1;
            end else if (!m_flush_now && st && !ex) begin
                m_op_active   = 1;
                m_ready_cycle = cyc + MC - 1;
            end
            if (ex) m_pc = EXC_VEC;
            m_flush_now = ex;
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, mon_cyc, got, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",             {26'd0, stall},            {26'd0, e[87:82]});
            chk("ex_multi_ready",    {31'd0, ex_multi_ready},   {31'd0, e[81]});
            chk("flush",             {31'd0, flush},            {31'd0, e[80]});
            chk("new_pc",            new_pc,                    e[79:48]);
            chk("perf_stall_cycles", perf_stall_cycles,         e[47:16]);
            chk("perf_flush_cnt",    {16'd0, perf_flush_cnt},   {16'd0, e[15:0]});
            if (ex_multi_ready === 1'b1) n_ready_seen++;
            mon_cyc++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset with every request asserted
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 1);
        drive(0, 1, 0, 0, 0);
        idle(2);
        // plain multi-cycle op
        drive(0, 0, 1, 0, 0);
        idle(4);
        // op stretched by two mem_wait cycles
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        idle(5);
        // exception aborts an op, restart right after the flush
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        idle(4);
        // MEM stall dominates ID, release same cycle
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        idle(1);
        // back-to-back exceptions
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        idle(2);
        // exception and start together
        drive(0, 0, 1, 0, 1);
        idle(3);
        // mem_wait in the completion cycle, start ignored during MULTI
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(2);
        // reset mid-op
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 12),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 3));
        end
        idle(2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        n_checks++;
        if (n_ready_seen == 0) begin
            n_errors++;
            $display("FAIL ready_seen got=0 exp=>0");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
